// File: rtl/vote_pkg.sv
// Shared definitions for the vote tally read side: count width, candidate codes, FSM states.
package vote_pkg;

  localparam int unsigned CNT_W_DEFAULT = 7;

  localparam logic [1:0] CAND_NONE = 2'd0;
  localparam logic [1:0] CAND1     = 2'd1;
  localparam logic [1:0] CAND2     = 2'd2;
  localparam logic [1:0] CAND3     = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StCmp1,
    StCmp2,
    StShow
  } state_e;

  // Auto-scroll order 1 -> 2 -> 3 -> 1.
  function automatic logic [1:0] next_cand(input logic [1:0] sel);
    logic [1:0] nxt;
    unique case (sel)
      CAND1:   nxt = CAND2;
      CAND2:   nxt = CAND3;
      default: nxt = CAND1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vote_result_reader_if.sv
// Bundle of tally inputs, candidate buttons and display outputs for vote_result_reader.
interface vote_result_reader_if #(
  parameter int unsigned CNT_W = vote_pkg::CNT_W_DEFAULT
);

  logic             mode;
  logic             cand1_button_valid;
  logic             cand2_button_valid;
  logic             cand3_button_valid;
  logic [CNT_W-1:0] cand1_vote_recvd;
  logic [CNT_W-1:0] cand2_vote_recvd;
  logic [CNT_W-1:0] cand3_vote_recvd;

  logic             result_valid;
  logic [1:0]       result_sel;
  logic [CNT_W-1:0] result_value;
  logic [1:0]       winner;
  logic             tie;
  logic             busy;

  modport master (
    output mode,
    output cand1_button_valid,
    output cand2_button_valid,
    output cand3_button_valid,
    output cand1_vote_recvd,
    output cand2_vote_recvd,
    output cand3_vote_recvd,
    input  result_valid,
    input  result_sel,
    input  result_value,
    input  winner,
    input  tie,
    input  busy
  );

  modport slave (
    input  mode,
    input  cand1_button_valid,
    input  cand2_button_valid,
    input  cand3_button_valid,
    input  cand1_vote_recvd,
    input  cand2_vote_recvd,
    input  cand3_vote_recvd,
    output result_valid,
    output result_sel,
    output result_value,
    output winner,
    output tie,
    output busy
  );

endinterface

// File: rtl/vote_dwell_timer.sv
// Auto-scroll dwell timer: pulses step once every DWELL_CYCLES enabled cycles; 0 disables it.
module vote_dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic step
);

  localparam int unsigned CntW = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DWELL_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (DWELL_CYCLES != 0)) begin
      if (cnt_q == LastCnt) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vote_result_reader.sv
// Result-mode reader: snapshots the three tallies on mode rise, finds winner/tie in two
// compare cycles, then shows one candidate's count selected by buttons or auto-scroll.
module vote_result_reader #(
  parameter int unsigned CNT_W        = vote_pkg::CNT_W_DEFAULT,
  parameter int unsigned DWELL_CYCLES = 100_000_000
) (
  input logic           clock,
  input logic           reset,
  vote_result_reader_if.slave bus
);

  import vote_pkg::*;

  state_e           state_q, state_d;
  logic             mode_q;
  logic [CNT_W-1:0] snap1_q, snap1_d;
  logic [CNT_W-1:0] snap2_q, snap2_d;
  logic [CNT_W-1:0] snap3_q, snap3_d;
  logic [1:0]       best_q, best_d;
  logic             tie12_q, tie12_d;
  logic [1:0]       winner_q, winner_d;
  logic             tie_q, tie_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] value_q, value_d;

  logic             rise, fall;
  logic             btn_any;
  logic [1:0]       btn_sel;
  logic             step;
  logic             timer_clear, timer_en;
  logic [CNT_W-1:0] best_cnt;
  logic [1:0]       cmp_win, cmp_sel;
  logic             cmp_tie;

  function automatic logic [CNT_W-1:0] cnt_of(input logic [1:0]       sel,
                                              input logic [CNT_W-1:0] c1,
                                              input logic [CNT_W-1:0] c2,
                                              input logic [CNT_W-1:0] c3);
    logic [CNT_W-1:0] v;
    unique case (sel)
      CAND1:   v = c1;
      CAND2:   v = c2;
      CAND3:   v = c3;
      default: v = '0;
    endcase
    return v;
  endfunction

  assign rise = bus.mode & ~mode_q;
  assign fall = ~bus.mode & mode_q;

  assign btn_any = bus.cand1_button_valid | bus.cand2_button_valid | bus.cand3_button_valid;
  assign btn_sel = bus.cand1_button_valid ? CAND1 :
                   bus.cand2_button_valid ? CAND2 : CAND3;

  // Dwell count only runs while showing; any button or leaving SHOW restarts it.
  assign timer_en    = (state_q == StShow);
  assign timer_clear = (state_q != StShow) | btn_any | fall;

  vote_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .clock (clock),
    .reset (reset),
    .clear (timer_clear),
    .enable(timer_en),
    .step  (step)
  );

  // Second compare stage: running best of c1/c2 against c3, lowest index wins ties.
  always_comb begin
    best_cnt = (best_q == CAND2) ? snap2_q : snap1_q;
    cmp_win  = best_q;
    cmp_tie  = tie12_q;
    if ((snap1_q | snap2_q | snap3_q) == '0) begin
      cmp_win = CAND_NONE;
      cmp_tie = 1'b0;
    end else if (snap3_q > best_cnt) begin
      cmp_win = CAND3;
      cmp_tie = 1'b0;
    end else if (snap3_q == best_cnt) begin
      cmp_tie = 1'b1;
    end
    cmp_sel = (cmp_win == CAND_NONE) ? CAND1 : cmp_win;
  end

  always_comb begin
    state_d  = state_q;
    snap1_d  = snap1_q;
    snap2_d  = snap2_q;
    snap3_d  = snap3_q;
    best_d   = best_q;
    tie12_d  = tie12_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    sel_d    = sel_q;
    value_d  = value_q;

    if ((state_q != StIdle) && fall) begin
      state_d  = StIdle;
      winner_d = CAND_NONE;
      tie_d    = 1'b0;
      busy_d   = 1'b0;
      valid_d  = 1'b0;
      sel_d    = CAND_NONE;
      value_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            snap1_d = bus.cand1_vote_recvd;
            snap2_d = bus.cand2_vote_recvd;
            snap3_d = bus.cand3_vote_recvd;
            busy_d  = 1'b1;
            state_d = StCmp1;
          end
        end
        StCmp1: begin
          best_d  = (snap2_q > snap1_q) ? CAND2 : CAND1;
          tie12_d = (snap1_q == snap2_q);
          state_d = StCmp2;
        end
        StCmp2: begin
          winner_d = cmp_win;
          tie_d    = cmp_tie;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          sel_d    = cmp_sel;
          value_d  = cnt_of(cmp_sel, snap1_q, snap2_q, snap3_q);
          state_d  = StShow;
        end
        StShow: begin
          if (btn_any) begin
            sel_d   = btn_sel;
            value_d = cnt_of(btn_sel, snap1_q, snap2_q, snap3_q);
          end else if (step) begin
            sel_d   = next_cand(sel_q);
            value_d = cnt_of(next_cand(sel_q), snap1_q, snap2_q, snap3_q);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      mode_q   <= 1'b0;
      snap1_q  <= '0;
      snap2_q  <= '0;
      snap3_q  <= '0;
      best_q   <= CAND_NONE;
      tie12_q  <= 1'b0;
      winner_q <= CAND_NONE;
      tie_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      sel_q    <= CAND_NONE;
      value_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= bus.mode;
      snap1_q  <= snap1_d;
      snap2_q  <= snap2_d;
      snap3_q  <= snap3_d;
      best_q   <= best_d;
      tie12_q  <= tie12_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      value_q  <= value_d;
    end
  end

  assign bus.result_valid = valid_q;
  assign bus.result_sel   = sel_q;
  assign bus.result_value = value_q;
  assign bus.winner       = winner_q;
  assign bus.tie          = tie_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vote_result_reader.sv
// Scoreboard bench for vote_result_reader: a behavioural model queues the expected outputs
// for every clock edge; a monitor pops and compares them after each edge.
module tb_vote_result_reader;

  localparam int unsigned CW = 7;
  localparam int unsigned DW = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  vote_result_reader_if #(.CNT_W(CW)) bus ();

  vote_result_reader #(
    .CNT_W       (CW),
    .DWELL_CYCLES(DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic          valid;
    logic [1:0]    sel;
    logic [CW-1:0] value;
    logic [1:0]    winner;
    logic          tie;
    logic          busy;
  } out_t;

  out_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model state.
  bit          m_mq;
  int          m_phase;   // 0 idle, 1/2 comparing, 3 showing
  int unsigned m_snap[1:3];
  int unsigned m_dwell;
  out_t        m_out;

  task automatic model_step();
    int unsigned c[1:3];
    bit          b[1:3];
    bit          rise, fall;
    int unsigned mx, n, w, s;
    c[1] = bus.cand1_vote_recvd;
    c[2] = bus.cand2_vote_recvd;
    c[3] = bus.cand3_vote_recvd;
    b[1] = bus.cand1_button_valid;
    b[2] = bus.cand2_button_valid;
    b[3] = bus.cand3_button_valid;
    if (reset) begin
      m_out   = '0;
      m_mq    = 1'b0;
      m_phase = 0;
      m_dwell = 0;
      for (int i = 1; i <= 3; i++) m_snap[i] = 0;
      return;
    end
    rise = bus.mode && !m_mq;
    fall = !bus.mode && m_mq;
    if (m_phase != 0 && fall) begin
      m_out   = '0;
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (rise) begin
          for (int i = 1; i <= 3; i++) m_snap[i] = c[i];
          m_out.busy = 1'b1;
          m_phase    = 1;
        end
        1: m_phase = 2;
        2: begin
          mx = 0;
          for (int i = 1; i <= 3; i++) if (m_snap[i] > mx) mx = m_snap[i];
          n = 0;
          w = 0;
          for (int i = 1; i <= 3; i++) begin
            if (m_snap[i] == mx) begin
              n++;
              if (w == 0) w = i;
            end
          end
          if (mx == 0) begin
            m_out.winner = 2'd0;
            m_out.tie    = 1'b0;
            s            = 1;
          end else begin
            m_out.winner = 2'(w);
            m_out.tie    = (n >= 2);
            s            = w;
          end
          m_out.sel   = 2'(s);
          m_out.value = CW'(m_snap[s]);
          m_out.valid = 1'b1;
          m_out.busy  = 1'b0;
          m_dwell     = 0;
          m_phase     = 3;
        end
        default: begin
          if (b[1] || b[2] || b[3]) begin
            s           = b[1] ? 1 : (b[2] ? 2 : 3);
            m_out.sel   = 2'(s);
            m_out.value = CW'(m_snap[s]);
            m_dwell     = 0;
          end else if (DW != 0) begin
            if (m_dwell == DW - 1) begin
              s           = (m_out.sel == 2'd3) ? 1 : int'(m_out.sel) + 1;
              m_out.sel   = 2'(s);
              m_out.value = CW'(m_snap[s]);
              m_dwell     = 0;
            end else begin
              m_dwell++;
            end
          end
        end
      endcase
    end
    m_mq = bus.mode;
  endtask

  // Model the coming edge from the inputs now driven, queue the result, then let it happen.
  task automatic tick();
    model_step();
    exp_q.push_back(m_out);
    @(negedge clock);
    bus.cand1_button_valid = 1'b0;
    bus.cand2_button_valid = 1'b0;
    bus.cand3_button_valid = 1'b0;
  endtask

  task automatic set_counts(input int unsigned a, input int unsigned b, input int unsigned c);
    bus.cand1_vote_recvd = CW'(a);
    bus.cand2_vote_recvd = CW'(b);
    bus.cand3_vote_recvd = CW'(c);
  endtask

  task automatic scramble_counts();
    set_counts($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
  endtask

  // Leave result mode, load counts, enter result mode and hold while the inputs wander.
  task automatic run_result(input int unsigned a, input int unsigned b, input int unsigned c,
                            input int hold);
    bus.mode = 1'b0;
    tick();
    set_counts(a, b, c);
    bus.mode = 1'b1;
    tick();
    for (int i = 0; i < hold; i++) begin
      scramble_counts();
      tick();
    end
  endtask

  // Monitor: compare the DUT against the queued expectation just after each rising edge.
  initial begin
    out_t e, a;
    int   n = 0;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        a.valid  = bus.result_valid;
        a.sel    = bus.result_sel;
        a.value  = bus.result_value;
        a.winner = bus.winner;
        a.tie    = bus.tie;
        a.busy   = bus.busy;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs edge %0d: got valid=%b sel=%0d value=%0d winner=%0d tie=%b busy=%b, want valid=%b sel=%0d value=%0d winner=%0d tie=%b busy=%b",
                   n, a.valid, a.sel, a.value, a.winner, a.tie, a.busy,
                   e.valid, e.sel, e.value, e.winner, e.tie, e.busy);
        end
        n++;
      end
    end
  end

  initial begin
    reset                  = 1'b1;
    bus.mode               = 1'b0;
    bus.cand1_button_valid = 1'b0;
    bus.cand2_button_valid = 1'b0;
    bus.cand3_button_valid = 1'b0;
    set_counts(0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 5/9/3: compare, ignored button during CMP1, buttons in SHOW, dwell scroll and restart.
    set_counts(5, 9, 3);
    bus.mode = 1'b1;
    tick();
    bus.cand2_button_valid = 1'b1;
    bus.cand3_button_valid = 1'b1;
    tick();
    tick();
    tick();
    bus.cand3_button_valid = 1'b1;
    tick();
    tick();
    bus.cand1_button_valid = 1'b1;
    bus.cand2_button_valid = 1'b1;
    tick();
    bus.cand2_button_valid = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      scramble_counts();
      tick();
    end
    tick();
    bus.cand3_button_valid = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();

    run_result(7, 7, 2, 5);
    run_result(4, 6, 6, 5);
    run_result(0, 0, 0, 6);
    run_result(9, 9, 9, 5);
    run_result(3, 3, 5, 5);
    run_result(1, 0, 8, 5);
    run_result(127, 126, 127, 5);

    // Reset during CMP1 with mode held high, then leave result mode.
    bus.mode = 1'b0;
    tick();
    set_counts(5, 9, 3);
    bus.mode = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus.mode = 1'b0;
    tick();
    tick();

    // Randomized traffic; small counts make ties and all-zero tallies common.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) bus.mode = ~bus.mode;
      bus.cand1_button_valid = ($urandom_range(0, 7) == 0);
      bus.cand2_button_valid = ($urandom_range(0, 7) == 0);
      bus.cand3_button_valid = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) begin
        set_counts($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        scramble_counts();
      end
      tick();
    end
    reset = 1'b0;
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
